// File: rtl/pwm_cfg_pkg.sv
// Shared register map, scheduler state encoding and register-bank type for pwm_cfg_scheduler.
package pwm_cfg_pkg;

  localparam logic [6:0] ADDR_EN_LO   = 7'd0;
  localparam logic [6:0] ADDR_EN_HI   = 7'd1;
  localparam logic [6:0] ADDR_MODE_LO = 7'd2;
  localparam logic [6:0] ADDR_MODE_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY    = 7'd4;
  localparam logic [6:0] MAX_ADDR     = 7'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] duty;
    logic [7:0] mode_hi;
    logic [7:0] mode_lo;
    logic [7:0] en_hi;
    logic [7:0] en_lo;
  } regbank_t;

  // Unmapped addresses leave the bank untouched.
  function automatic regbank_t bank_write(input regbank_t b, input logic [6:0] addr,
                                          input logic [7:0] data);
    regbank_t r;
    r = b;
    case (addr)
      ADDR_EN_LO:   r.en_lo   = data;
      ADDR_EN_HI:   r.en_hi   = data;
      ADDR_MODE_LO: r.mode_lo = data;
      ADDR_MODE_HI: r.mode_hi = data;
      ADDR_DUTY:    r.duty    = data;
      default:      r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM prescaler and period counter; flags each counter step (tick) and the period wrap (boundary).
module pwm_timebase #(
  parameter int PRESCALE   = 3000,
  parameter int PERIOD_MAX = 254
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pwm_cnt,
  output logic       tick,
  output logic       boundary
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    CNT_LAST = 8'(PERIOD_MAX);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;

  assign tick     = (presc_q == PRE_LAST);
  assign boundary = tick && (cnt_q == CNT_LAST);
  assign pwm_cnt  = cnt_q;

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// Stages register writes in a shadow bank and commits them at PWM period boundaries.
// Define ERR_COUNT_EN to add the saturating illegal-write counter output err_cnt.
module pwm_cfg_scheduler #(
  parameter int PRESCALE   = 3000,
  parameter int MAX_ADDR   = 4,
  parameter int PERIOD_MAX = 254
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  output logic        commit,
  output logic        pending,
  output logic [7:0]  pwm_cnt,
  output logic [15:0] out_pins
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  import pwm_cfg_pkg::state_t;
  import pwm_cfg_pkg::regbank_t;
  import pwm_cfg_pkg::bank_write;
  import pwm_cfg_pkg::IDLE;
  import pwm_cfg_pkg::PENDING;
  import pwm_cfg_pkg::COMMIT;

  localparam logic [6:0] ADDR_LIMIT = 7'(MAX_ADDR);

  state_t      state_q, state_d;
  regbank_t    shadow_q, shadow_d;
  regbank_t    active_q, active_d;
  logic        pending_q, pending_d;
  logic        wr_err_q, commit_q;
  logic [15:0] out_pins_q, out_d;
  logic        boundary;
  logic        tick_unused;
  logic        xfer, legal, pwm_lvl;
  logic [15:0] en, mode;

  pwm_timebase #(
    .PRESCALE   (PRESCALE),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .pwm_cnt  (pwm_cnt),
    .tick     (tick_unused),
    .boundary (boundary)
  );

  // No transfer during the copy cycle, so nothing can race active <= shadow.
  assign wr_ready = !rst && (state_q != COMMIT);
  assign xfer     = wr_valid && wr_ready;
  assign legal    = (wr_addr <= ADDR_LIMIT);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (xfer && legal) begin
      shadow_d = bank_write(shadow_q, wr_addr, wr_data);
    end
    case (state_q)
      IDLE: begin
        if (xfer && legal) begin
          state_d   = PENDING;
          pending_d = 1'b1;
        end
      end
      PENDING: begin
        if (boundary) state_d = COMMIT;
      end
      COMMIT: begin
        active_d  = shadow_q;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign en      = {active_q.en_hi, active_q.en_lo};
  assign mode    = {active_q.mode_hi, active_q.mode_lo};
  assign pwm_lvl = (active_q.duty == 8'h00) ? 1'b0 :
                   (active_q.duty == 8'hFF) ? 1'b1 : (pwm_cnt < active_q.duty);

  for (genvar gi = 0; gi < 16; gi++) begin : g_pin
    assign out_d[gi] = en[gi] & (mode[gi] ? pwm_lvl : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      commit_q   <= 1'b0;
      out_pins_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      wr_err_q   <= xfer && !legal;
      commit_q   <= (state_q == PENDING) && boundary;
      out_pins_q <= out_d;
    end
  end

  assign wr_err   = wr_err_q;
  assign commit   = commit_q;
  assign pending  = pending_q;
  assign out_pins = out_pins_q;

`ifdef ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (xfer && !legal && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Scoreboard bench for pwm_cfg_scheduler with a short prescaler; expected out_pins are queued with their due cycle.
module tb_pwm_cfg_scheduler;

  localparam int P = 4;
  localparam int T = 255 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_addr = 7'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_ready, wr_err, commit, pending;
  logic [7:0]  pwm_cnt;
  logic [15:0] out_pins;
`ifdef ERR_COUNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  pwm_cfg_scheduler #(
    .PRESCALE   (P),
    .MAX_ADDR   (4),
    .PERIOD_MAX (254)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .commit   (commit),
    .pending  (pending),
    .pwm_cnt  (pwm_cnt),
    .out_pins (out_pins)
`ifdef ERR_COUNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  // Clock edges since reset was last released.
  int n;
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] pins;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int due, input logic [15:0] pins);
    exp_t e;
    e.due  = due;
    e.pins = pins;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("pwm_cnt", {24'd0, pwm_cnt}, 32'((n / P) % 255));
      while (exp_q.size() > 0 && exp_q[0].due < n) begin
        check("sb_due", n, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == n) begin
        check("sb_pins", {16'd0, out_pins}, {16'd0, exp_q[0].pins});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_to(input int t);
    int g;
    g = 0;
    while (n < t && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check("wait_to", n, t);
  endtask

  // Returns at the negedge after the transfer; waits counts cycles spent with wr_ready low.
  task automatic wr(input logic [6:0] a, input logic [7:0] d, output int waits);
    logic rdy;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    waits    = 0;
    $display("wr addr=%0d data=%02h n=%0d", a, d, n);
    while (1) begin
      rdy = wr_ready;
      @(negedge clk);
      if (rdy) break;
      waits++;
      if (waits > 8) begin
        check("wr_timeout", waits, 0);
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int w;
    int cl[4];
    cl[0] = 0; cl[1] = 127; cl[2] = 128; cl[3] = 254;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rdy_rst", wr_ready, 0);
    check("pins_rst", out_pins, 0);
    check("pend_rst", pending, 0);
    check("cnt_rst", pwm_cnt, 0);
    check("commit_rst", commit, 0);
    check("err_rst", wr_err, 0);
    rst = 1'b0;
    #1;
    check("rdy_idle", wr_ready, 1);

    // Two idle periods.
    wait_to(2 * T);
    check("pins_idle", out_pins, 0);
    check("pend_idle", pending, 0);

    // Mid-period write is held until the boundary.
    wait_to(2 * T + 300);
    wr(7'd0, 8'hFF, w);
    check("pend_set", pending, 1);
    check("pins_hold", out_pins, 0);
    push_exp(3 * T, 16'h0000);
    push_exp(3 * T + 1, 16'h0000);
    push_exp(3 * T + 2, 16'h00FF);
    wait_to(3 * T - 1);
    check("commit_pre", commit, 0);
    check("pend_pre", pending, 1);
    wait_to(3 * T);
    check("commit_pulse", commit, 1);
    check("rdy_commit", wr_ready, 0);
    wait_to(3 * T + 1);
    check("commit_once", commit, 0);
    check("pend_clr", pending, 0);

    // 50% duty on pin 0 in PWM mode.
    wait_to(3 * T + 10);
    wr(7'd4, 8'h80, w);
    wr(7'd2, 8'h01, w);
    wr(7'd0, 8'h01, w);
    push_exp(4 * T + 1, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      push_exp(4 * T + P * cl[i] + 2, (cl[i] < 128) ? 16'h0001 : 16'h0000);
    end

    // duty 0x00 is always low.
    wait_to(4 * T + 600);
    wr(7'd4, 8'h00, w);
    push_exp(5 * T + 2, 16'h0000);
    push_exp(5 * T + P * 100 + 2, 16'h0000);
    push_exp(5 * T + P * 254 + 2, 16'h0000);

    // duty 0xFF is always high.
    wait_to(5 * T + 600);
    wr(7'd4, 8'hFF, w);
    push_exp(6 * T + 2, 16'h0001);
    push_exp(6 * T + P * 254 + 2, 16'h0001);

    // Illegal address: error pulse, nothing staged.
    wait_to(6 * T + 50);
    wr(7'd5, 8'h55, w);
    check("err_pulse", wr_err, 1);
    check("err_pend", pending, 0);
    @(negedge clk);
    check("err_once", wr_err, 0);
`ifdef ERR_COUNT_EN
    check("err_cnt1", err_cnt, 1);
    for (int i = 0; i < 255; i++) wr(7'd5, 8'h55, w);
    @(negedge clk);
    check("err_cnt_sat", err_cnt, 255);
`endif
    wait_to(7 * T);
    check("idle_bnd_commit", commit, 0);
    check("idle_bnd_pend", pending, 0);

    // Stage en_lo, then a write landing on the boundary edge joins the same commit.
    wait_to(7 * T + 100);
    check("pins_ffduty", out_pins, 16'h0001);
    wr(7'd0, 8'h0F, w);
    push_exp(8 * T + 1, 16'h0001);
    push_exp(8 * T + 2, 16'hA50F);
    wait_to(8 * T - 1);
    wr(7'd1, 8'hA5, w);
    check("bnd_wait", w, 0);
    check("bnd_commit", commit, 1);
    check("bnd_rdy", wr_ready, 0);
    // Held valid in COMMIT transfers one cycle later.
    wr(7'd0, 8'hF0, w);
    check("stall_waits", w, 1);
    check("stall_pend", pending, 1);
    push_exp(9 * T + 1, 16'hA50F);
    push_exp(9 * T + 2, 16'hA5F0);

    // Reset with a write staged discards it.
    wait_to(9 * T + 100);
    wr(7'd0, 8'h3C, w);
    check("rst_pend_set", pending, 1);
    wait_to(9 * T + 200);
    check("sb_drained", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pins", out_pins, 0);
    check("rst_pend", pending, 0);
    check("rst_cnt", pwm_cnt, 0);
    check("rst_commit", commit, 0);
    check("rst_err", wr_err, 0);
`ifdef ERR_COUNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    wait_to(T);
    check("post_rst_commit", commit, 0);
    check("post_rst_pend", pending, 0);
    wait_to(T + 5);
    check("post_rst_pins", out_pins, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
